// File: rtl/hcpu_pkg.sv
// rtl/hcpu_pkg.sv - shared opcodes and FSM state encoding for the HiddenCPU gen2 core
// Contents: OPC_W, the 4-bit opcode constants OP_NOP..OP_HALT, and the core FSM
// state type state_e (ST_RUN, ST_LDW, ST_HALT).
// Opcode 4'hD is OP_CLC in the default build and OP_MUL when HCPU_MUL_EN is defined.
package hcpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h6;
    localparam logic [OPC_W-1:0] OP_INC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_ST   = 4'h8;
    localparam logic [OPC_W-1:0] OP_LD   = 4'h9;
    localparam logic [OPC_W-1:0] OP_BCS  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hB;
    localparam logic [OPC_W-1:0] OP_TGL  = 4'hC;
    localparam logic [OPC_W-1:0] OP_CLC  = 4'hD;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'hD;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LDW  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/hcpu_alu.sv
// rtl/hcpu_alu.sv - combinational ALU for the HiddenCPU gen2 core
// Ports: op (opcode), a (R = r[rd]), b (S = r[rs]) in; result (new R),
// carry_out (new carry), carry_we (carry updates), rd_we (r[rd] updates) out.
// Handles ADD, SUB, AND, OR, XOR, MOV, INC, SHL and opcode D, which is CLC by
// default or MUL when HCPU_MUL_EN is defined. Other opcodes assert no write enables.
module hcpu_alu
    import hcpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              carry_we,
    output logic              rd_we
);

`ifdef HCPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        carry_we  = 1'b0;
        rd_we     = 1'b0;
        case (op)
            OP_ADD: begin
                {carry_out, result} = {1'b0, a} + {1'b0, b};
                carry_we = 1'b1;
                rd_we    = 1'b1;
            end
            OP_SUB: begin
                result    = a - b;
                carry_out = (a < b);
                carry_we  = 1'b1;
                rd_we     = 1'b1;
            end
            OP_AND: begin
                result = a & b;
                rd_we  = 1'b1;
            end
            OP_OR: begin
                result = a | b;
                rd_we  = 1'b1;
            end
            OP_XOR: begin
                result = a ^ b;
                rd_we  = 1'b1;
            end
            OP_MOV: begin
                result = b;
                rd_we  = 1'b1;
            end
            OP_INC: begin
                {carry_out, result} = {1'b0, a} + (DATA_W + 1)'(1);
                carry_we = 1'b1;
                rd_we    = 1'b1;
            end
`ifdef HCPU_MUL_EN
            OP_MUL: begin
                // carry flags any overflow into the upper half of the product
                result    = prod[DATA_W-1:0];
                carry_out = |prod[2*DATA_W-1:DATA_W];
                carry_we  = 1'b1;
                rd_we     = 1'b1;
            end
`else
            OP_CLC: begin
                carry_out = 1'b0;
                carry_we  = 1'b1;
            end
`endif
            OP_SHL: begin
                result    = {a[DATA_W-2:0], 1'b0};
                carry_out = a[DATA_W-1];
                carry_we  = 1'b1;
                rd_we     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/hidden_cpu_gen2.sv
// rtl/hidden_cpu_gen2.sv - HiddenCPU gen2 accumulator core (register file, RAM, PC, FSM)
// Ports: clk; rst (asynchronous, active-low); instr_valid/instr/instr_ready form the
// instruction stream, one word per cycle where valid & ready; pc_out is the next
// fetch address; dout shows r[NREGS-1], or the PC while sel_q is set; carry is the
// carry flag; halted is high in the HALT state.
// Build option HCPU_MUL_EN: opcode D becomes MUL instead of CLC (inside hcpu_alu).
module hidden_cpu_gen2
    import hcpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NREGS     = 4,
    parameter int RAM_DEPTH = 16,
    parameter int PC_W      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instr_valid,
    input  logic [OPC_W+2*$clog2(NREGS)-1:0] instr,
    output logic                             instr_ready,
    output logic [PC_W-1:0]                  pc_out,
    output logic [DATA_W-1:0]                dout,
    output logic                             carry,
    output logic                             halted
);

    localparam int RA_W = $clog2(NREGS);
    localparam int MA_W = $clog2(RAM_DEPTH);

    logic [OPC_W-1:0]  opcode;
    logic [RA_W-1:0]   rd_idx;
    logic [RA_W-1:0]   rs_idx;
    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] s_val;
    logic              accept;

    logic [DATA_W-1:0] r_q [NREGS];
    logic [DATA_W-1:0] r_d [NREGS];
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              carry_q, carry_d;
    logic              sel_q, sel_d;
    state_e            state_q, state_d;
    logic [RA_W-1:0]   ld_rd_q, ld_rd_d;
    logic [MA_W-1:0]   ld_addr_q, ld_addr_d;
    logic              ready_q, ready_d;
    logic              halted_q, halted_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_carry_we;
    logic              alu_rd_we;

    assign opcode = instr[OPC_W+2*RA_W-1 -: OPC_W];
    assign rd_idx = instr[2*RA_W-1 -: RA_W];
    assign rs_idx = instr[RA_W-1:0];
    assign r_val  = r_q[rd_idx];
    assign s_val  = r_q[rs_idx];

    // ready_q is low in LDW and HALT, so nothing is accepted there
    assign accept = instr_valid & ready_q;

    hcpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op        (opcode),
        .a         (r_val),
        .b         (s_val),
        .result    (alu_result),
        .carry_out (alu_carry),
        .carry_we  (alu_carry_we),
        .rd_we     (alu_rd_we)
    );

    always_comb begin
        r_d       = r_q;
        pc_d      = pc_q;
        carry_d   = carry_q;
        sel_d     = sel_q;
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_addr_d = ld_addr_q;

        if (state_q == ST_LDW) begin
            // second half of LD: the registered address reads RAM into rd
            r_d[ld_rd_q] = ram_q[ld_addr_q];
            state_d      = ST_RUN;
        end else if (accept) begin
            pc_d = pc_q + PC_W'(1);
            if (alu_rd_we) begin
                r_d[rd_idx] = alu_result;
            end
            if (alu_carry_we) begin
                carry_d = alu_carry;
            end
            case (opcode)
                OP_LD: begin
                    ld_rd_d   = rd_idx;
                    ld_addr_d = MA_W'(s_val);
                    state_d   = ST_LDW;
                end
                OP_BCS: begin
                    // offset is relative to the BCS itself, not to pc+1
                    if (carry_q) begin
                        pc_d = pc_q + PC_W'(s_val);
                    end
                end
                OP_JMP:  pc_d    = PC_W'(s_val);
                OP_TGL:  sel_d   = ~sel_q;
                OP_HALT: state_d = ST_HALT;
                default: begin
                end
            endcase
        end

        ready_d  = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_q[i] <= DATA_W'(i);
            end
            pc_q      <= '0;
            carry_q   <= 1'b0;
            sel_q     <= 1'b0;
            state_q   <= ST_RUN;
            ld_rd_q   <= '0;
            ld_addr_q <= '0;
            ready_q   <= 1'b1;
            halted_q  <= 1'b0;
        end else begin
            r_q       <= r_d;
            pc_q      <= pc_d;
            carry_q   <= carry_d;
            sel_q     <= sel_d;
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_addr_q <= ld_addr_d;
            ready_q   <= ready_d;
            halted_q  <= halted_d;
        end
    end

    // RAM has no reset; ST writes at its accept edge so a following LD sees it
    always_ff @(posedge clk) begin
        if (accept && opcode == OP_ST) begin
            ram_q[MA_W'(s_val)] <= r_val;
        end
    end

    assign instr_ready = ready_q;
    assign halted      = halted_q;
    assign pc_out      = pc_q;
    assign carry       = carry_q;
    assign dout        = sel_q ? DATA_W'(pc_q) : r_q[NREGS-1];

endmodule

// File: tb/tb_hidden_cpu_gen2.sv
// tb/tb_hidden_cpu_gen2.sv - self-checking bench for hidden_cpu_gen2
module tb_hidden_cpu_gen2;

    localparam int DW   = 8;
    localparam int NR   = 4;
    localparam int PW   = 8;
    localparam int RD   = 16;
    localparam int DMOD = 1 << DW;
    localparam int PMOD = 1 << PW;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        instr_valid = 1'b0;
    logic [7:0]  instr       = '0;
    logic        instr_ready, carry, halted;
    logic [7:0]  pc_out, dout;

    logic        instr_valid2 = 1'b0;
    logic [9:0]  instr2       = '0;
    logic        instr_ready2, carry2, halted2;
    logic [3:0]  pc_out2;
    logic [15:0] dout2;

    int total = 0;
    int bad   = 0;

    int m_r [NR];
    int m_ram [RD];
    bit m_known [RD];
    int m_pc, m_carry, m_sel, m_ldw, m_halt, m_ld_rd, m_ld_addr;

    always #5 clk = ~clk;

    hidden_cpu_gen2 #(
        .DATA_W(8), .NREGS(4), .RAM_DEPTH(16), .PC_W(8)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .pc_out(pc_out), .dout(dout),
        .carry(carry), .halted(halted)
    );

    hidden_cpu_gen2 #(
        .DATA_W(16), .NREGS(8), .RAM_DEPTH(16), .PC_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid2), .instr(instr2),
        .instr_ready(instr_ready2), .pc_out(pc_out2), .dout(dout2),
        .carry(carry2), .halted(halted2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int op, input int rd, input int rs);
        return 8'((op << 4) | (rd << 2) | rs);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = i % DMOD;
        m_pc = 0; m_carry = 0; m_sel = 0; m_ldw = 0; m_halt = 0;
    endtask

    // architectural effect of one clock edge given the inputs presented before it
    task automatic model_step(input bit v, input int ins);
        int op, rd, rs, a, b, t, npc;
        if (m_halt != 0) return;
        if (m_ldw != 0) begin
            m_r[m_ld_rd] = m_ram[m_ld_addr];
            m_ldw = 0;
            return;
        end
        if (!v) return;
        op = (ins >> 4) & 15;
        rd = (ins >> 2) & 3;
        rs = ins & 3;
        a = m_r[rd];
        b = m_r[rs];
        npc = (m_pc + 1) % PMOD;
        case (op)
            1:  begin t = a + b; m_r[rd] = t % DMOD; m_carry = (t >= DMOD); end
            2:  begin m_r[rd] = (a - b + DMOD) % DMOD; m_carry = (a < b); end
            3:  m_r[rd] = a & b;
            4:  m_r[rd] = a | b;
            5:  m_r[rd] = a ^ b;
            6:  m_r[rd] = b;
            7:  begin t = a + 1; m_r[rd] = t % DMOD; m_carry = (t >= DMOD); end
            8:  begin m_ram[b % RD] = a; m_known[b % RD] = 1'b1; end
            9:  begin m_ld_rd = rd; m_ld_addr = b % RD; m_ldw = 1; end
            10: if (m_carry != 0) npc = (m_pc + b) % PMOD;
            11: npc = b % PMOD;
            12: m_sel = 1 - m_sel;
`ifdef HCPU_MUL_EN
            13: begin t = a * b; m_r[rd] = t % DMOD; m_carry = ((t / DMOD) != 0); end
`else
            13: m_carry = 0;
`endif
            14: begin t = a * 2; m_r[rd] = t % DMOD; m_carry = t / DMOD; end
            15: m_halt = 1;
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check_outs(input string tag);
        check({tag, " ready"},  instr_ready, (m_halt == 0 && m_ldw == 0));
        check({tag, " halted"}, halted, m_halt);
        check({tag, " pc"},     pc_out, m_pc);
        check({tag, " carry"},  carry, m_carry);
        check({tag, " dout"},   dout, (m_sel != 0) ? (m_pc % DMOD) : m_r[NR-1]);
    endtask

    task automatic step(input bit v, input logic [7:0] ins, input string tag);
        instr_valid = v;
        instr = ins;
        model_step(v, int'(ins));
        @(negedge clk);
        check_outs(tag);
    endtask

    // called just after a falling edge; reset lands mid-cycle, outputs checked before the next rise
    task automatic async_reset(input string tag);
        instr_valid = 1'b0;
        #2 rst = 1'b0;
        #1 model_reset();
        check_outs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step2(input int op, input int rd, input int rs);
        instr_valid2 = 1'b1;
        instr2 = 10'((op << 6) | (rd << 3) | rs);
        @(negedge clk);
        instr_valid2 = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset");
        check("reset dout const", dout, 3);
        check("reset ready const", instr_ready, 1);
        rst = 1'b1;

        step(1, enc(1, 3, 2), "add");
        check("add r3 dout", dout, 5);
        check("add pc", pc_out, 1);
        check("add carry", carry, 0);
        step(1, enc(14, 1, 1), "shl1");
        step(1, enc(14, 1, 1), "shl2");
        step(1, enc(2, 3, 3), "sub_clr");
        step(1, enc(7, 0, 0), "inc_r0");
        step(1, enc(2, 3, 0), "sub_ff");
        check("ff dout", dout, 8'hFF);
        check("ff borrow", carry, 1);
        step(1, enc(6, 0, 3), "mov_r0");
        step(1, enc(7, 0, 0), "inc_wrap");
        check("inc wrap carry", carry, 1);
        step(1, enc(6, 3, 0), "mov_r3");
        check("inc wrap value", dout, 0);
        step(1, enc(0, 0, 0), "nop");
        check("pc before bcs", pc_out, 10);
        step(1, enc(10, 0, 1), "bcs_taken");
        check("bcs taken pc", pc_out, 14);
`ifdef HCPU_MUL_EN
        step(1, enc(2, 0, 0), "clr_carry");
`else
        step(1, enc(13, 0, 0), "clc");
`endif
        check("carry cleared", carry, 0);
        step(1, enc(10, 0, 1), "bcs_not");
        check("bcs not taken pc", pc_out, 16);

        step(1, enc(1, 3, 1), "add_r3");
        step(1, enc(7, 3, 3), "inc_r3");
        step(1, enc(8, 3, 2), "st");
        step(1, enc(9, 0, 2), "ld");
        check("ld stall ready", instr_ready, 0);
        step(1, enc(15, 0, 0), "ldw_ignore");
        check("ldw ready back", instr_ready, 1);
        check("ldw pc", pc_out, 20);
        check("ldw not halted", halted, 0);
        step(1, enc(2, 3, 3), "sub_r3");
        step(1, enc(6, 3, 0), "mov_ld");
        check("st-ld data", dout, 5);
        step(1, enc(12, 0, 0), "tgl");
        check("tgl shows pc", dout, 8'h17);
        step(1, enc(0, 0, 0), "tgl_nop");
        step(1, enc(12, 0, 0), "tgl_back");
        check("tgl back r3", dout, 5);
        for (int i = 0; i < 3; i++) step(0, 8'($urandom_range(0, 255)), "idle");
        check("idle pc", pc_out, 25);

        step(1, enc(9, 3, 2), "ld_abort");
        async_reset("ldw_rst");
        check("ldw reset pc", pc_out, 0);
        step(1, enc(0, 0, 0), "after_abort");
        check("load aborted", dout, 3);

        for (int n = 0; n < 800; n++) begin
            int op, rd, rs;
            op = $urandom_range(0, 14);
            rd = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            if (op == 9 && !m_known[m_r[rs] % RD]) op = 8;
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
            else step($urandom_range(0, 3) != 0, enc(op, rd, rs), "rand");
        end

        async_reset("pre_halt");
        for (int i = 0; i < 7; i++) step(1, enc(0, 0, 0), "halt_nop");
        step(1, enc(15, 0, 0), "halt");
        check("halt flag", halted, 1);
        check("halt ready", instr_ready, 0);
        check("halt pc", pc_out, 8);
        for (int i = 0; i < 4; i++) step(1, enc(1, 3, 3), "halted_ignore");
        check("halted pc hold", pc_out, 8);
        async_reset("halt_rst");
        check("halt rst halted", halted, 0);
        check("halt rst pc", pc_out, 0);
        check("halt rst r3", dout, 3);

        step2(1, 7, 6);
        step2(1, 7, 6);
        check("w16 r7", dout2, 16'h0013);
        check("w16 pc", pc_out2, 2);
        step2(11, 0, 7);
        check("w16 jmp pc", pc_out2, 3);
        step2(2, 6, 6);
        step2(7, 6, 6);
        for (int i = 0; i < 14; i++) step2(14, 6, 6);
        step2(13, 5, 6);
        step2(6, 7, 5);
`ifdef HCPU_MUL_EN
        check("w16 mul low", dout2, 16'h4000);
        check("w16 mul carry", carry2, 1);
`else
        check("w16 clc keeps r5", dout2, 16'h0005);
        check("w16 clc carry", carry2, 0);
`endif
        step2(6, 7, 6);
        check("w16 shl chain", dout2, 16'h4000);
        check("w16 pc wrap", pc_out2, 6);
        check("w16 ready", instr_ready2, 1);
        check("w16 halted", halted2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hidden_cpu_gen2.md
Name: hidden_cpu_gen2

Overview:
Parametrised second-generation HiddenCPU core: a register-to-register accumulator CPU whose instructions are streamed in over a valid/ready port, one word per accepted cycle.
- Generalised in data width, register count, RAM depth and PC width.
- Adds a 16-op ISA, a multi-cycle load with stall, an absolute jump and a halt state.
- Sits behind the chip-level pin wrapper; the wrapper serialises `dout` and `pc_out` onto the shared IO.

Parameters:
- DATA_W, 8, register/ALU/RAM data width (≥4)
- NREGS, 4, register count, power of two (≥2); RA_W = log2(NREGS)
- RAM_DEPTH, 16, internal RAM words, power of two; MA_W = log2(RAM_DEPTH)
- PC_W, 8, program counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- instr_valid  in  1  instruction word present
- instr  in  4+2*RA_W  instruction: [top 4]=opcode, [next RA_W]=rd, [low RA_W]=rs
- instr_ready  out  1  core can accept instr this cycle
- pc_out  out  PC_W  address of the next instruction to fetch
- dout  out  DATA_W  sel_q ? pc zero-extended/truncated to DATA_W : r[NREGS-1]
- carry  out  1  carry flag
- halted  out  1  core in HALT state

Behaviour:
- Reset (rst=0, asynchronous):
  - r[i]=i mod 2^DATA_W; pc=0; carry=0; sel_q=0; state=RUN.
  - Resulting outputs: instr_ready=1, halted=0.
  - RAM contents are not reset.
- Accept: an instruction is accepted when instr_valid & instr_ready at the clock edge. With no accept, no architectural state changes.
- PC update: every accepted instruction advances pc to pc+1 mod 2^PC_W, unless a taken branch or jump overrides it.
- States:
  - RUN: instr_ready=1.
  - LDW: load-wait; instr_ready=0, lasts exactly 1 cycle, then RUN.
  - HALT: instr_ready=0, halted=1; left only by reset.
- Opcodes: R=r[rd], S=r[rs], all arithmetic mod 2^DATA_W.
  - 0 NOP.
  - 1 ADD: R=R+S, carry=carry-out.
  - 2 SUB: R=R-S, carry=borrow (R<S).
  - 3 AND, 4 OR, 5 XOR: bitwise, carry unchanged.
  - 6 MOV: R=S.
  - 7 INC: R=R+1, carry=carry-out.
  - 8 ST: RAM[S[MA_W-1:0]]=R, written at the accept edge.
  - 9 LD: address registered at the accept edge, state→LDW. In LDW, a synchronous RAM read writes rd at the next edge.
  - A BCS: if carry, pc=pc+S (PC of the BCS itself plus S, zero-extended/truncated to PC_W, modular); else pc+1.
  - B JMP: pc=S zero-extended/truncated to PC_W.
  - C TGL: sel_q=~sel_q.
  - D CLC: carry=0.
  - E SHL: R=R<<1, carry=old R[DATA_W-1].
  - F HALT: pc still increments, state→HALT.
- Boundaries:
  - rd==rs is legal and uses the old value (e.g. ADD r1,r1 doubles r1).
  - ST immediately followed by LD to the same address returns the new data.
  - PC wraps from 2^PC_W-1 to 0 silently.
  - Reset asserted during LDW aborts the load; rd takes its reset value.
  - instr is ignored while instr_ready=0.
  - Bits of an RAM address above MA_W are ignored.

Optional Feature:
HCPU_MUL_EN:
- Defined: opcode D is MUL. R = low DATA_W bits of R*S; carry = |high DATA_W bits. Single cycle; CLC is unavailable (use SUB rX,rX to clear carry).
- Undefined: opcode D is CLC and no multiplier is instantiated.

Decomposition:
- Package hcpu_pkg:
  - 4-bit opcode localparams (OP_NOP … OP_HALT).
  - State encoding (ST_RUN, ST_LDW, ST_HALT).
  - OPC_W=4 constant.
- One sub-module, hcpu_alu (parametrised DATA_W): combinational ops 1–7, D, E. Outputs result, carry_out, carry_we, rd_we.
- Top-level module holds the register file, RAM, PC, FSM and sel_q.

Test Plan:
- Reset then ADD r3,r2 (defaults) → r3=5, dout=5, carry=0, pc_out=1.
- DATA_W=8: MOV r0←r3 (0xFF preloaded via SHL/INC chain), INC r0 → r0=0x00, carry=1. Then BCS r1 at pc=10 with r1=4 → pc_out=14. CLC; repeat BCS → pc_out=pc+1.
- ST r3 at [r2=2], then LD r0 from [r2] back-to-back → instr_ready=0 for exactly one cycle after LD accept; r0=r3; pc_out advanced by 2 total.
- TGL then NOP → dout switches from r3 to pc (e.g. 0x02); second TGL returns to r3. instr_valid=0 cycles leave pc and registers unchanged.
- HALT at pc=7 → halted=1, instr_ready=0, pc_out=8. Further valid instr ignored; rst=0 mid-cycle → immediate halted=0, pc_out=0, r[i]=i.
- NREGS=8, DATA_W=16, PC_W=4: JMP r7 with r7=0x0013 → pc_out=3. With HCPU_MUL_EN, MUL r5,r6 (5×0x4000) → r5=0x4000, carry=1.
